// File: rtl/nyan_pkg.sv
// Shared types and constants for the nyan-cat animation sequencer:
// layer encodings, FSM states and per-pose sprite bounding boxes.
package nyan_pkg;

  localparam int unsigned COORD_W        = 10;
  localparam int unsigned TEX_W          = 5;
  localparam int unsigned SCALE_LOG2_DEF = 3;
  localparam int unsigned NUM_LAYERS     = 3;

  typedef enum logic [1:0] {
    LAYER_BASE = 2'd0,
    LAYER_FEET = 2'd1,
    LAYER_TAIL = 2'd2,
    LAYER_NONE = 2'd3
  } layer_t;

  typedef enum logic [1:0] {
    ST_RUN          = 2'd0,
    ST_PAUSE        = 2'd1,
    ST_STEP_PENDING = 2'd2
  } state_t;

  // Half-open box [left,right) x [top,bottom) in screen pixels
  typedef struct packed {
    logic [COORD_W-1:0] left;
    logic [COORD_W-1:0] right;
    logic [COORD_W-1:0] top;
    logic [COORD_W-1:0] bottom;
  } box_t;

  localparam box_t BASE_P0 = '{left: 10'd236, right: 10'd452, top: 10'd160, bottom: 10'd296};
  localparam box_t FEET_P0 = '{left: 10'd228, right: 10'd428, top: 10'd296, bottom: 10'd320};
  localparam box_t TAIL_P0 = '{left: 10'd188, right: 10'd236, top: 10'd224, bottom: 10'd272};
  localparam box_t BASE_P1 = '{left: 10'd236, right: 10'd452, top: 10'd165, bottom: 10'd301};
  localparam box_t FEET_P1 = '{left: 10'd236, right: 10'd428, top: 10'd301, bottom: 10'd325};
  localparam box_t TAIL_P1 = '{left: 10'd188, right: 10'd236, top: 10'd253, bottom: 10'd293};

  // Layer index 0 base, 1 feet, 2 tail; odd_pose selects the second pose
  function automatic box_t layer_box(input int unsigned idx, input logic odd_pose);
    box_t b;
    b = odd_pose ? BASE_P1 : BASE_P0;
    case (idx)
      1:       b = odd_pose ? FEET_P1 : FEET_P0;
      2:       b = odd_pose ? TAIL_P1 : TAIL_P0;
      default: b = odd_pose ? BASE_P1 : BASE_P0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/nyan_layer_hit.sv
// Single sprite box test: in-box hit plus coordinate offset from the box origin.
module nyan_layer_hit
  import nyan_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  box_t               box,
  output logic               hit_c,
  output logic [COORD_W-1:0] off_x_c,
  output logic [COORD_W-1:0] off_y_c
);

  assign hit_c   = (x >= box.left) && (x < box.right) &&
                   (y >= box.top)  && (y < box.bottom);
  assign off_x_c = x - box.left;
  assign off_y_c = y - box.top;

endmodule

// File: rtl/nyan_sequencer.sv
// Animation phase sequencer (run/pause/step with frame hold counter) and
// two-stage per-pixel sprite layer arbitration for the nyan-cat datapath.
module nyan_sequencer
  import nyan_pkg::*;
#(
  parameter int unsigned SCALE_LOG2 = SCALE_LOG2_DEF,
  parameter int unsigned HOLD_BITS  = 5,
  parameter int unsigned NUM_PHASES = 2,
  parameter int unsigned PHASE_W    = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic [COORD_W-1:0]   pixel_x,
  input  logic [COORD_W-1:0]   pixel_y,
  input  logic                 pixel_valid,
  input  logic                 cfg_enable,
  input  logic [HOLD_BITS-1:0] cfg_hold,
  input  logic                 step_req,
  output logic [PHASE_W-1:0]   phase,
  output logic                 layer_valid,
  output logic [1:0]           layer_sel,
  output logic [TEX_W-1:0]     tex_x,
  output logic [TEX_W-1:0]     tex_y,
  output logic                 out_valid
);

  state_t               state, next_state;
  logic [HOLD_BITS-1:0] cnt, next_cnt, hold_max;
  logic [PHASE_W-1:0]   next_phase;
  logic                 advance;
  logic                 run_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
      phase <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      phase <= next_phase;
    end
  end

  // RUN/PAUSE follow cfg_enable in the same cycle, so a coincident frame_start acts in the new mode
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_phase = phase;
    advance    = 1'b0;
    hold_max   = (cfg_hold == '0) ? '0 : cfg_hold - HOLD_BITS'(1);
    case (state)
      ST_RUN:   next_state = cfg_enable ? ST_RUN : ST_PAUSE;
      ST_PAUSE: begin
        if (cfg_enable)    next_state = ST_RUN;
        else if (step_req) next_state = ST_STEP_PENDING;
      end
      ST_STEP_PENDING: begin
        if (frame_start) begin
          advance    = 1'b1;
          next_state = cfg_enable ? ST_RUN : ST_PAUSE;
        end
      end
      default:  next_state = ST_RUN;
    endcase
    run_now = (state != ST_STEP_PENDING) && (next_state == ST_RUN);
    if (!run_now) begin
      next_cnt = '0;
    end else if (frame_start) begin
      if (cnt >= hold_max) begin
        next_cnt = '0;
        advance  = 1'b1;
      end else begin
        next_cnt = cnt + HOLD_BITS'(1);
      end
    end
    if (advance) begin
      next_phase = (phase == PHASE_W'(NUM_PHASES - 1)) ? '0 : phase + PHASE_W'(1);
    end
  end

  logic [NUM_LAYERS-1:0]              hit_c;
  logic [NUM_LAYERS-1:0][COORD_W-1:0] off_x_c, off_y_c;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    nyan_layer_hit u_hit (
      .x       (pixel_x),
      .y       (pixel_y),
      .box     (layer_box(g, phase[0])),
      .hit_c   (hit_c[g]),
      .off_x_c (off_x_c[g]),
      .off_y_c (off_y_c[g])
    );
  end

  logic [NUM_LAYERS-1:0]              s1_hit;
  logic [NUM_LAYERS-1:0][COORD_W-1:0] s1_off_x, s1_off_y;
  logic                               s1_valid;

  // Stage 1: box hits and offsets, gated by pixel_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hit   <= '0;
      s1_off_x <= '0;
      s1_off_y <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_hit   <= pixel_valid ? hit_c : '0;
      s1_off_x <= off_x_c;
      s1_off_y <= off_y_c;
      s1_valid <= pixel_valid;
    end
  end

  layer_t             sel_c;
  logic [COORD_W-1:0] ox_c, oy_c;

  // Fixed priority base > feet > tail
  always_comb begin
    sel_c = LAYER_NONE;
    ox_c  = '0;
    oy_c  = '0;
    if (s1_hit[0]) begin
      sel_c = LAYER_BASE;
      ox_c  = s1_off_x[0];
      oy_c  = s1_off_y[0];
    end else if (s1_hit[1]) begin
      sel_c = LAYER_FEET;
      ox_c  = s1_off_x[1];
      oy_c  = s1_off_y[1];
    end else if (s1_hit[2]) begin
      sel_c = LAYER_TAIL;
      ox_c  = s1_off_x[2];
      oy_c  = s1_off_y[2];
    end
  end

  // Stage 2: winning layer and texel coordinates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer_valid <= 1'b0;
      layer_sel   <= LAYER_NONE;
      tex_x       <= '0;
      tex_y       <= '0;
      out_valid   <= 1'b0;
    end else begin
      layer_valid <= (sel_c != LAYER_NONE);
      layer_sel   <= sel_c;
      tex_x       <= TEX_W'(ox_c >> SCALE_LOG2);
      tex_y       <= TEX_W'(oy_c >> SCALE_LOG2);
      out_valid   <= s1_valid;
    end
  end

endmodule

// File: tb/tb_nyan_sequencer.sv
// Directed bench for nyan_sequencer: phase sequencing modes and layer arbitration.
module tb_nyan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic [9:0] pixel_x, pixel_y;
  logic       pixel_valid;
  logic       cfg_enable;
  logic [4:0] cfg_hold;
  logic       step_req;
  logic [0:0] phase;
  logic       layer_valid;
  logic [1:0] layer_sel;
  logic [4:0] tex_x, tex_y;
  logic       out_valid;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       v;
    logic [1:0] sel;
    logic [4:0] tx;
    logic [4:0] ty;
  } vec_t;

  nyan_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_valid (pixel_valid),
    .cfg_enable  (cfg_enable),
    .cfg_hold    (cfg_hold),
    .step_req    (step_req),
    .phase       (phase),
    .layer_valid (layer_valid),
    .layer_sel   (layer_sel),
    .tex_x       (tex_x),
    .tex_y       (tex_y),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  // Present one pixel, then idle a cycle so its result sits at the outputs
  task automatic pixel(input logic [9:0] x, input logic [9:0] y, input logic v);
    pixel_x     = x;
    pixel_y     = y;
    pixel_valid = v;
    tick();
    pixel_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    total++;
    if ({phase, layer_valid, layer_sel, tex_x, tex_y, out_valid} !== {1'b0, 1'b0, 2'd3, 5'd0, 5'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset: phase=%0d lv=%0d sel=%0d tex=(%0d,%0d) ov=%0d expected 0,0,3,(0,0),0",
               phase, layer_valid, layer_sel, tex_x, tex_y, out_valid);
    end
  endtask

  task automatic test_hold16();
    logic exp;
    cfg_hold = 5'd16;
    for (int n = 1; n <= 32; n++) begin
      frame();
      exp = ((n / 16) % 2) == 1;
      total++;
      if (phase !== exp) begin
        bad++;
        $display("FAIL hold16 frame %0d: phase=%0d expected %0d", n, phase, exp);
      end
    end
  endtask

  task automatic test_geometry_p0();
    vec_t vecs[9];
    vecs = '{
      '{10'd300, 10'd200, 1'b1, 2'd0, 5'd8,  5'd5},
      '{10'd230, 10'd300, 1'b1, 2'd1, 5'd0,  5'd0},
      '{10'd200, 10'd230, 1'b1, 2'd2, 5'd1,  5'd0},
      '{10'd100, 10'd100, 1'b1, 2'd3, 5'd0,  5'd0},
      '{10'd452, 10'd200, 1'b1, 2'd3, 5'd0,  5'd0},
      '{10'd451, 10'd295, 1'b1, 2'd0, 5'd26, 5'd16},
      '{10'd236, 10'd296, 1'b1, 2'd1, 5'd1,  5'd0},
      '{10'd200, 10'd260, 1'b1, 2'd2, 5'd1,  5'd4},
      '{10'd300, 10'd200, 1'b0, 2'd3, 5'd0,  5'd0}
    };
    foreach (vecs[i]) begin
      pixel(vecs[i].x, vecs[i].y, vecs[i].v);
      total++;
      if ({layer_valid, layer_sel, tex_x, tex_y, out_valid} !==
          {vecs[i].sel != 2'd3, vecs[i].sel, vecs[i].tx, vecs[i].ty, vecs[i].v}) begin
        bad++;
        $display("FAIL geom_p0 (%0d,%0d): lv=%0d sel=%0d tex=(%0d,%0d) ov=%0d expected sel=%0d tex=(%0d,%0d) ov=%0d",
                 vecs[i].x, vecs[i].y, layer_valid, layer_sel, tex_x, tex_y, out_valid,
                 vecs[i].sel, vecs[i].tx, vecs[i].ty, vecs[i].v);
      end
    end
  endtask

  task automatic test_geometry_p1();
    vec_t vecs[5];
    vecs = '{
      '{10'd200, 10'd260, 1'b1, 2'd2, 5'd1,  5'd0},
      '{10'd230, 10'd300, 1'b1, 2'd3, 5'd0,  5'd0},
      '{10'd300, 10'd200, 1'b1, 2'd0, 5'd8,  5'd4},
      '{10'd236, 10'd301, 1'b1, 2'd1, 5'd0,  5'd0},
      '{10'd451, 10'd300, 1'b1, 2'd0, 5'd26, 5'd16}
    };
    foreach (vecs[i]) begin
      pixel(vecs[i].x, vecs[i].y, vecs[i].v);
      total++;
      if ({layer_valid, layer_sel, tex_x, tex_y, out_valid} !==
          {vecs[i].sel != 2'd3, vecs[i].sel, vecs[i].tx, vecs[i].ty, vecs[i].v}) begin
        bad++;
        $display("FAIL geom_p1 (%0d,%0d): lv=%0d sel=%0d tex=(%0d,%0d) ov=%0d expected sel=%0d tex=(%0d,%0d) ov=%0d",
                 vecs[i].x, vecs[i].y, layer_valid, layer_sel, tex_x, tex_y, out_valid,
                 vecs[i].sel, vecs[i].tx, vecs[i].ty, vecs[i].v);
      end
    end
  endtask

  task automatic test_pause_step();
    cfg_enable = 1'b0;
    tick();
    for (int n = 1; n <= 40; n++) begin
      frame();
      total++;
      if (phase !== 1'b0) begin
        bad++;
        $display("FAIL pause frame %0d: phase=%0d expected 0", n, phase);
      end
    end
    for (int k = 0; k < 2; k++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      tick();
    end
    total++;
    if (phase !== 1'b0) begin
      bad++;
      $display("FAIL step_before_frame: phase=%0d expected 0", phase);
    end
    frame();
    total++;
    if (phase !== 1'b1) begin
      bad++;
      $display("FAIL step_advance: phase=%0d expected 1", phase);
    end
    frame();
    total++;
    if (phase !== 1'b1) begin
      bad++;
      $display("FAIL step_not_queued: phase=%0d expected 1", phase);
    end
  endtask

  task automatic test_resume();
    cfg_enable = 1'b1;
    cfg_hold   = 5'd2;
    frame();
    total++;
    if (phase !== 1'b1) begin
      bad++;
      $display("FAIL resume frame 1: phase=%0d expected 1", phase);
    end
    frame();
    total++;
    if (phase !== 1'b0) begin
      bad++;
      $display("FAIL resume frame 2: phase=%0d expected 0", phase);
    end
  endtask

  task automatic test_hold_lower();
    cfg_hold = 5'd8;
    for (int n = 0; n < 3; n++) frame();
    total++;
    if (phase !== 1'b0) begin
      bad++;
      $display("FAIL hold8 partial: phase=%0d expected 0", phase);
    end
    cfg_hold = 5'd2;
    frame();
    total++;
    if (phase !== 1'b1) begin
      bad++;
      $display("FAIL hold_lowered: phase=%0d expected 1", phase);
    end
  endtask

  task automatic test_hold_zero();
    logic exp;
    cfg_hold = 5'd0;
    exp = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      frame();
      exp = ~exp;
      total++;
      if (phase !== exp) begin
        bad++;
        $display("FAIL hold0 frame %0d: phase=%0d expected %0d", n, phase, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    pixel_x     = 10'd300;
    pixel_y     = 10'd200;
    pixel_valid = 1'b1;
    tick();
    tick();
    total++;
    if ({phase, layer_sel, tex_x, tex_y} !== {1'b1, 2'd0, 5'd8, 5'd4}) begin
      bad++;
      $display("FAIL pre_reset: phase=%0d sel=%0d tex=(%0d,%0d) expected 1,0,(8,4)",
               phase, layer_sel, tex_x, tex_y);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({phase, layer_valid, layer_sel, tex_x, tex_y, out_valid} !== {1'b0, 1'b0, 2'd3, 5'd0, 5'd0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset: phase=%0d lv=%0d sel=%0d tex=(%0d,%0d) ov=%0d expected 0,0,3,(0,0),0",
               phase, layer_valid, layer_sel, tex_x, tex_y, out_valid);
    end
    #2;
    rst_n = 1'b1;
    tick();
    total++;
    if ({layer_valid, layer_sel, out_valid} !== {1'b0, 2'd3, 1'b0}) begin
      bad++;
      $display("FAIL post_release: lv=%0d sel=%0d ov=%0d expected 0,3,0", layer_valid, layer_sel, out_valid);
    end
    tick();
    total++;
    if ({phase, layer_valid, layer_sel, tex_x, tex_y, out_valid} !== {1'b0, 1'b1, 2'd0, 5'd8, 5'd5, 1'b1}) begin
      bad++;
      $display("FAIL post_release_pixel: phase=%0d lv=%0d sel=%0d tex=(%0d,%0d) ov=%0d expected 0,1,0,(8,5),1",
               phase, layer_valid, layer_sel, tex_x, tex_y, out_valid);
    end
    pixel_valid = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    pixel_x     = '0;
    pixel_y     = '0;
    pixel_valid = 1'b0;
    cfg_enable  = 1'b1;
    cfg_hold    = 5'd16;
    step_req    = 1'b0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_hold16();
    test_geometry_p0();
    test_pause_step();
    test_geometry_p1();
    test_resume();
    test_hold_lower();
    test_hold_zero();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
